// File: rtl/cache_fill_sm.sv
// Cache line-fill engine: fetches a missed line one word per memory request,
// writes each returned word into the data array, then writes the tag and signals completion.
module cache_fill_sm #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int WORDS_LOG2 = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  miss_req,
   input  logic [ADDR_W-1:0]     miss_addr,
   output logic                  mem_rd_req,
   output logic [ADDR_W-1:0]     mem_rd_addr,
   input  logic                  mem_rd_gnt,
   input  logic                  mem_rd_valid,
   input  logic [DATA_W-1:0]     mem_rd_data,
   output logic                  line_we,
   output logic [WORDS_LOG2-1:0] line_word,
   output logic [DATA_W-1:0]     line_wdata,
   output logic                  tag_we,
   output logic [ADDR_W-1:0]     tag_addr,
   output logic                  mem_done,
   output logic [2:0]            fill_state
);

   localparam int LINE_WORDS = 1 << WORDS_LOG2;
   localparam logic [WORDS_LOG2:0] CNT_FULL = (WORDS_LOG2+1)'(LINE_WORDS);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ISSUE  = 3'd1,
      WAIT   = 3'd2,
      COMMIT = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   base, base_nxt;
   logic [ADDR_W-1:0]   addr_hold, tag_hold;
   logic [WORDS_LOG2:0] issue_cnt, issue_nxt;
   logic [WORDS_LOG2:0] recv_cnt, recv_nxt;

   // Address outputs are re-registered every cycle so they hold when unqualified.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         base      <= '0;
         issue_cnt <= '0;
         recv_cnt  <= '0;
         addr_hold <= '0;
         tag_hold  <= '0;
      end else begin
         state     <= state_nxt;
         base      <= base_nxt;
         issue_cnt <= issue_nxt;
         recv_cnt  <= recv_nxt;
         addr_hold <= mem_rd_addr;
         tag_hold  <= tag_addr;
      end
   end

   always_comb begin
      state_nxt   = state;
      base_nxt    = base;
      issue_nxt   = issue_cnt;
      recv_nxt    = recv_cnt;
      mem_rd_req  = 1'b0;
      mem_rd_addr = addr_hold;
      line_we     = 1'b0;
      line_word   = '0;
      line_wdata  = '0;
      tag_we      = 1'b0;
      tag_addr    = tag_hold;
      mem_done    = 1'b0;

      case (state)
         IDLE: begin
            if (miss_req) begin
               base_nxt                   = miss_addr;
               base_nxt[WORDS_LOG2-1:0]   = '0;
               issue_nxt                  = '0;
               recv_nxt                   = '0;
               state_nxt                  = ISSUE;
            end
         end
         ISSUE, WAIT: begin
            if (state == ISSUE) begin
               mem_rd_req  = 1'b1;
               mem_rd_addr = {base[ADDR_W-1:WORDS_LOG2], issue_cnt[WORDS_LOG2-1:0]};
               if (mem_rd_gnt) begin
                  issue_nxt = issue_cnt + 1'b1;
                  if (issue_nxt == CNT_FULL) state_nxt = WAIT;
               end
            end
            // A completed line wins over the ISSUE->WAIT move.
            if (mem_rd_valid && (recv_cnt < CNT_FULL)) begin
               line_we    = 1'b1;
               line_word  = recv_cnt[WORDS_LOG2-1:0];
               line_wdata = mem_rd_data;
               recv_nxt   = recv_cnt + 1'b1;
               if (recv_nxt == CNT_FULL) state_nxt = COMMIT;
            end
         end
         COMMIT: begin
            tag_we    = 1'b1;
            tag_addr  = base;
            state_nxt = DONE;
         end
         DONE: begin
            mem_done  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign fill_state = state;

endmodule

// File: tb/tb_cache_fill_sm.sv
// Randomized bench for cache_fill_sm against a transaction-level fill model
// with an in-order memory responder.
module tb_cache_fill_sm;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int WL = 2;
   localparam int LW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          miss_req = 1'b0;
   logic [AW-1:0] miss_addr = '0;
   logic          mem_rd_req;
   logic [AW-1:0] mem_rd_addr;
   logic          mem_rd_gnt = 1'b0;
   logic          mem_rd_valid = 1'b0;
   logic [DW-1:0] mem_rd_data = '0;
   logic          line_we;
   logic [WL-1:0] line_word;
   logic [DW-1:0] line_wdata;
   logic          tag_we;
   logic [AW-1:0] tag_addr;
   logic          mem_done;
   logic [2:0]    fill_state;

   always #5 clk = ~clk;

   cache_fill_sm #(.ADDR_W(AW), .DATA_W(DW), .WORDS_LOG2(WL)) dut (
      .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
      .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_gnt(mem_rd_gnt),
      .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
      .line_we(line_we), .line_word(line_word), .line_wdata(line_wdata),
      .tag_we(tag_we), .tag_addr(tag_addr), .mem_done(mem_done), .fill_state(fill_state)
   );

   int compared = 0;
   int mismatched = 0;
   int cyc_n = 0;

   // Fill model: words issued/received for the active line, plus the two trailing cycles
   bit            m_act;
   int            m_iss, m_rcv, m_tail;
   logic [AW-1:0] m_base, m_last_addr, m_last_tag;
   logic          exp_req, exp_we;
   logic [AW-1:0] exp_addr, exp_taddr;
   logic [104:0]  exp_v, obs_v;

   logic          o_req, o_we, o_tw, o_done;
   logic [AW-1:0] o_addr, o_taddr;
   logic [WL-1:0] o_word;
   logic [2:0]    o_st;

   typedef struct { int due; logic [AW-1:0] addr; } ret_t;
   ret_t          pend[$];
   bit            from_q;
   int            gnt_pct = 100, lat_lo = 1, lat_hi = 1;
   logic [31:0]   salt = 32'h0;

   function automatic logic [DW-1:0] mem_word(logic [AW-1:0] a);
      return (a * 32'h9E37_79B1) ^ salt;
   endfunction

   task automatic eval_model();
      logic [WL-1:0] wd;
      logic [DW-1:0] wdat;
      logic          tw, dn;
      logic [2:0]    st;
      exp_req   = m_act && (m_iss < LW);
      exp_addr  = exp_req ? m_base + m_iss : m_last_addr;
      exp_we    = m_act && mem_rd_valid && (m_rcv < LW);
      wd        = exp_we ? WL'(m_rcv) : '0;
      wdat      = exp_we ? mem_rd_data : '0;
      tw        = (m_tail == 1);
      exp_taddr = tw ? m_base : m_last_tag;
      dn        = (m_tail == 2);
      if (m_act)            st = (m_iss < LW) ? 3'd1 : 3'd2;
      else if (m_tail == 1) st = 3'd3;
      else if (m_tail == 2) st = 3'd4;
      else                  st = 3'd0;
      exp_v = {exp_req, exp_addr, exp_we, wd, wdat, tw, exp_taddr, dn, st};
   endtask

   task automatic update_model();
      if (from_q && mem_rd_valid) void'(pend.pop_front());
      if (rst && exp_req && mem_rd_gnt)
         pend.push_back('{due: cyc_n + int'($urandom_range(lat_hi, lat_lo)), addr: exp_addr});
      if (!rst) begin
         m_act = 0; m_iss = 0; m_rcv = 0; m_tail = 0;
         m_last_addr = '0; m_last_tag = '0;
      end else begin
         m_last_addr = exp_addr;
         m_last_tag  = exp_taddr;
         if (m_act) begin
            if (exp_req && mem_rd_gnt) m_iss++;
            if (exp_we) m_rcv++;
            if (m_rcv == LW) begin m_act = 0; m_tail = 1; end
         end else if (m_tail == 1) m_tail = 2;
         else if (m_tail == 2) m_tail = 0;
         else if (miss_req) begin
            m_act = 1; m_iss = 0; m_rcv = 0;
            m_base = miss_addr & ~AW'(LW - 1);
         end
      end
   endtask

   task automatic drive_mem();
      mem_rd_gnt   = ($urandom_range(99, 0) < gnt_pct);
      from_q       = (pend.size() > 0) && (pend[0].due <= cyc_n);
      mem_rd_valid = from_q;
      mem_rd_data  = from_q ? mem_word(pend[0].addr) : $urandom;
   endtask

   // Called during the low phase with inputs applied; returns at the next negedge.
   task automatic cyc();
      #1;
      eval_model();
      o_req = mem_rd_req; o_addr = mem_rd_addr; o_we = line_we; o_word = line_word;
      o_tw = tag_we; o_taddr = tag_addr; o_done = mem_done; o_st = fill_state;
      obs_v = {mem_rd_req, mem_rd_addr, line_we, line_word, line_wdata,
               tag_we, tag_addr, mem_done, fill_state};
      @(posedge clk);
      update_model();
      cyc_n++;
      @(negedge clk);
   endtask

   task automatic settle();
      int n = 0;
      miss_req = 1'b0;
      while ((m_act || m_tail != 0 || pend.size() > 0) && n < 60) begin
         drive_mem(); cyc(); n++;
         compared++;
         if (obs_v !== exp_v) begin
            mismatched++;
            $display("FAIL settle cyc%0d got %h want %h", n, obs_v, exp_v);
         end
      end
      compared++;
      if (n >= 60) begin
         mismatched++;
         $display("FAIL settle_timeout got busy want idle");
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; miss_req = 1'b1; miss_addr = 32'hFFFF_FFFF;
      mem_rd_gnt = 1'b1; mem_rd_valid = 1'b1; from_q = 1'b0;
      cyc(); cyc();
      compared++;
      if (obs_v !== '0) begin
         mismatched++;
         $display("FAIL reset_outputs got %h want 0", obs_v);
      end
      rst = 1'b1; miss_req = 1'b0; mem_rd_valid = 1'b0; mem_rd_gnt = 1'b0;
      cyc();
      compared++;
      if (obs_v !== exp_v || o_st !== 3'd0) begin
         mismatched++;
         $display("FAIL reset_release got %h want %h", obs_v, exp_v);
      end
   endtask

   task automatic test_basic();
      logic [7:0] want, got;
      salt = $urandom; gnt_pct = 100; lat_lo = 1; lat_hi = 1;
      miss_addr = 32'h1236;
      for (int k = 0; k < 10; k++) begin
         miss_req = (k == 0);
         drive_mem(); cyc();
         compared++;
         if (obs_v !== exp_v) begin
            mismatched++;
            $display("FAIL basic_model cyc%0d got %h want %h", k, obs_v, exp_v);
         end
         want = {(k >= 1 && k <= 4), (k >= 2 && k <= 5), (k == 6), (k == 7), 4'h0};
         got  = {o_req, o_we, o_tw, o_done, 4'h0};
         compared++;
         if (got !== want) begin
            mismatched++;
            $display("FAIL basic_strobes cyc%0d got %h want %h", k, got, want);
         end
         if (k >= 1 && k <= 4) begin
            compared++;
            if (o_addr !== 32'h1234 + 32'(k - 1)) begin
               mismatched++;
               $display("FAIL basic_addr cyc%0d got %h want %h", k, o_addr, 32'h1234 + 32'(k - 1));
            end
         end
         if (k >= 2 && k <= 5) begin
            compared++;
            if (o_word !== WL'(k - 2)) begin
               mismatched++;
               $display("FAIL basic_word cyc%0d got %0d want %0d", k, o_word, k - 2);
            end
         end
         if (k == 6) begin
            compared++;
            if (o_taddr !== 32'h1234) begin
               mismatched++;
               $display("FAIL basic_tag_addr got %h want 00001234", o_taddr);
            end
         end
      end
      settle();
   endtask

   task automatic test_throttle();
      int grants = 0, writes = 0, dones = 0, k = 0;
      salt = $urandom; lat_lo = 3; lat_hi = 3;
      miss_addr = $urandom;
      while (dones == 0 && k < 60) begin
         miss_req = (k == 0);
         drive_mem();
         mem_rd_gnt = k[0];
         cyc();
         compared++;
         if (obs_v !== exp_v) begin
            mismatched++;
            $display("FAIL throttle_model cyc%0d got %h want %h", k, obs_v, exp_v);
         end
         if (o_req && mem_rd_gnt) grants++;
         if (o_we) begin
            compared++;
            if (o_word !== WL'(writes)) begin
               mismatched++;
               $display("FAIL throttle_order got %0d want %0d", o_word, writes);
            end
            writes++;
         end
         if (o_done) dones++;
         k++;
      end
      compared++;
      if (grants != LW || writes != LW || dones != 1) begin
         mismatched++;
         $display("FAIL throttle_counts got g%0d w%0d d%0d want g4 w4 d1", grants, writes, dones);
      end
      settle();
   endtask

   task automatic test_spurious();
      salt = $urandom; gnt_pct = 100; lat_lo = 1; lat_hi = 1;
      miss_req = 1'b0;
      for (int k = 0; k < 2; k++) begin
         drive_mem();
         mem_rd_valid = 1'b1; from_q = 1'b0;
         cyc();
         compared++;
         if (o_we !== 1'b0 || o_st !== 3'd0) begin
            mismatched++;
            $display("FAIL spurious_idle got we%b st%0d want we0 st0", o_we, o_st);
         end
      end
      miss_addr = $urandom;
      for (int k = 0; k < 12; k++) begin
         miss_req = (k == 0);
         drive_mem();
         if (m_tail == 1) begin mem_rd_valid = 1'b1; from_q = 1'b0; end
         cyc();
         compared++;
         if (obs_v !== exp_v) begin
            mismatched++;
            $display("FAIL spurious_model cyc%0d got %h want %h", k, obs_v, exp_v);
         end
         if (o_st == 3'd3) begin
            compared++;
            if (o_we !== 1'b0) begin
               mismatched++;
               $display("FAIL spurious_commit got we%b want we0", o_we);
            end
         end
      end
      settle();
   endtask

   task automatic test_drop();
      int dones = 0;
      salt = $urandom; gnt_pct = 60; lat_lo = 1; lat_hi = 4;
      miss_addr = $urandom;
      for (int k = 0; k < 60; k++) begin
         miss_req = (k < 2);
         drive_mem(); cyc();
         compared++;
         if (obs_v !== exp_v) begin
            mismatched++;
            $display("FAIL drop_model cyc%0d got %h want %h", k, obs_v, exp_v);
         end
         if (o_done) dones++;
      end
      compared++;
      if (dones != 1) begin
         mismatched++;
         $display("FAIL drop_done_count got %0d want 1", dones);
      end
      settle();
   endtask

   task automatic test_reset_mid();
      int phase = 0, k = 0;
      logic [AW-1:0] nb;
      salt = $urandom; gnt_pct = 100; lat_lo = 3; lat_hi = 3;
      miss_addr = $urandom;
      while (phase < 2 && k < 30) begin
         miss_req = (k == 0);
         drive_mem();
         rst = !(phase == 0 && m_act && m_iss == LW && m_rcv == 2);
         cyc();
         rst = 1'b1;
         if (phase == 1) begin
            compared++;
            if (obs_v !== '0) begin
               mismatched++;
               $display("FAIL rstmid_outputs got %h want 0", obs_v);
            end
            phase = 2;
         end else begin
            compared++;
            if (obs_v !== exp_v) begin
               mismatched++;
               $display("FAIL rstmid_model cyc%0d got %h want %h", k, obs_v, exp_v);
            end
            if (m_act == 0 && m_tail == 0 && k > 0) phase = 1;
         end
         k++;
      end
      compared++;
      if (phase != 2) begin
         mismatched++;
         $display("FAIL rstmid_timeout got phase%0d want 2", phase);
      end
      for (int j = 0; j < 4; j++) begin
         drive_mem(); cyc();
         compared++;
         if (o_we !== 1'b0 || o_st !== 3'd0) begin
            mismatched++;
            $display("FAIL rstmid_late_return got we%b st%0d want we0 st0", o_we, o_st);
         end
      end
      pend.delete();
      miss_addr = $urandom;
      nb = miss_addr & ~AW'(LW - 1);
      miss_req = 1'b1; drive_mem(); cyc();
      miss_req = 1'b0; drive_mem(); cyc();
      compared++;
      if (o_req !== 1'b1 || o_addr !== nb) begin
         mismatched++;
         $display("FAIL rstmid_restart got req%b %h want req1 %h", o_req, o_addr, nb);
      end
      settle();
   endtask

   task automatic test_back_to_back();
      int dphase = -1;
      salt = $urandom; gnt_pct = 100; lat_lo = 1; lat_hi = 1;
      miss_addr = 32'h80;
      for (int k = 0; k < 30; k++) begin
         miss_req = (dphase < 1);
         if (m_tail == 2 && dphase < 0) miss_addr = 32'h40;
         drive_mem(); cyc();
         compared++;
         if (obs_v !== exp_v) begin
            mismatched++;
            $display("FAIL b2b_model cyc%0d got %h want %h", k, obs_v, exp_v);
         end
         if (dphase == 0) begin
            compared++;
            if (o_st !== 3'd0) begin
               mismatched++;
               $display("FAIL b2b_idle got st%0d want st0", o_st);
            end
         end else if (dphase == 1) begin
            compared++;
            if (o_st !== 3'd1 || o_req !== 1'b1 || o_addr !== 32'h40) begin
               mismatched++;
               $display("FAIL b2b_second got st%0d req%b %h want st1 req1 00000040", o_st, o_req, o_addr);
            end
         end
         if (dphase >= 0) dphase++;
         else if (o_done) dphase = 0;
      end
      compared++;
      if (dphase < 2) begin
         mismatched++;
         $display("FAIL b2b_timeout got phase%0d want 2", dphase);
      end
      settle();
   endtask

   task automatic test_random();
      int dones = 0;
      salt = $urandom;
      for (int k = 0; k < 600; k++) begin
         if (k % 50 == 0) begin
            gnt_pct = $urandom_range(100, 30);
            lat_lo  = $urandom_range(2, 1);
            lat_hi  = $urandom_range(6, 2);
         end
         miss_req  = ($urandom_range(99, 0) < 30);
         miss_addr = $urandom;
         drive_mem(); cyc();
         compared++;
         if (obs_v !== exp_v) begin
            mismatched++;
            $display("FAIL random_model cyc%0d got %h want %h", k, obs_v, exp_v);
         end
         if (o_done) dones++;
      end
      compared++;
      if (dones < 5) begin
         mismatched++;
         $display("FAIL random_progress got %0d fills want >=5", dones);
      end
      settle();
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_throttle();
      test_spurious();
      test_drop();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
